spi_mem_loader: RTL and testbench
=================================

Name: spi_mem_loader

Overview:
Parametrised successor to the SPI-to-RAM boot path. It accepts deserialised words from the SPI slave and buffers them in an internal FIFO. It parses framed packets (header, base address, N data words, checksum) and issues one-outstanding memory write transactions. It holds the core in reset until an explicit RUN command is received. It sits between spi_slave and the instruction/data RAM port.

Parameters:
DATA_WIDTH, 32, word width of SPI words and memory data; multiple of 8, minimum 32
ADDR_WIDTH, 32, memory byte-address width
FIFO_DEPTH, 8, receive FIFO entries; power of two, minimum 2

Ports:
clk_sys_i  in  1  system clock
rst_sys_i  in  1  asynchronous active-high reset
rx_valid_i  in  1  one-cycle pulse: rx_data_i holds a complete SPI word
rx_data_i  in  DATA_WIDTH  received word
ss_i  in  1  SPI chip select from pad, active low; asynchronous to clk_sys_i
mem_req_o  out  1  memory request
mem_gnt_i  in  1  memory grant
mem_rvalid_i  in  1  memory response valid
mem_we_o  out  1  write enable; 1 whenever mem_req_o=1
mem_addr_o  out  ADDR_WIDTH  byte address
mem_wdata_o  out  DATA_WIDTH  write data
mem_be_o  out  DATA_WIDTH/8  byte enables; all ones during requests
core_rst_no  out  1  core reset, active low
busy_o  out  1  FSM not in IDLE
done_o  out  1  one-cycle pulse: burst checksum OK
err_valid_o  out  1  one-cycle pulse: packet error
err_code_o  out  2  0 none, 1 bad header, 2 checksum mismatch, 3 abort
overflow_o  out  1  sticky: FIFO was full on rx_valid_i

Behaviour:
- Reset values: every output is 0, including core_rst_no (core held in reset). FIFO is empty. FSM is in IDLE.
- ss_i passes through a 2-flop synchroniser. ss_hi is the synchronised value.
- FIFO push: on rx_valid_i when not full. When full, the word is dropped and overflow_o is set. overflow_o clears only on reset.
- FIFO pop: FSM consumes the head word in the same cycle it samples it. Simultaneous push and pop on a full FIFO is allowed.
- Header word fields:
  - opcode = bits[DATA_WIDTH-1:DATA_WIDTH-8].
  - len = bits[15:0].
  - opcode 0xA5 = WRITE: drive core_rst_no=0 in the cycle after the header pop.
  - opcode 0x5A = RUN: set core_rst_no=1, no further words.
  - Any other opcode, or WRITE with len=0: err_code=1 and err_valid_o pulse; flush FIFO; go to IDLE.
- FSM states:
  - IDLE: pop header.
  - ADDR: pop base address, keep low ADDR_WIDTH bits, clear sum.
  - DATA: pop word, add it to sum mod 2^DATA_WIDTH, load mem_wdata_o.
  - REQ: mem_req_o=1 with addr/data/be stable until the cycle mem_gnt_i=1. mem_req_o deasserts in the cycle after the grant.
  - RESP: wait for mem_rvalid_i. Then address += DATA_WIDTH/8 (wraps mod 2^ADDR_WIDTH) and remaining -= 1. Go to CHECK if remaining=0, else DATA.
  - CHECK: pop word. Equal to sum: done_o pulse. Unequal: err_code=2 and err_valid_o pulse; written data is not rolled back. Then IDLE.
- Only one memory transaction is outstanding. mem_rvalid_i outside RESP is ignored.
- Abort: FSM in ADDR, DATA or CHECK, FIFO empty and ss_hi=1 → err_code=3, err_valid_o pulse, flush FIFO, go to IDLE.
  - An abort does not interrupt REQ/RESP; it is evaluated at the next pop state.
- Words arriving while the FSM is in IDLE after an error are parsed as new headers.
- err_code_o holds its value until the next valid header pop, which clears it to 0.
- busy_o = (state != IDLE).
- core_rst_no stays at its last value across errors; a WRITE keeps it at 0 until a RUN.
- Asynchronous reset mid-burst: all state cleared immediately, mem_req_o=0. Any in-flight response is ignored.

Test Plan:
1. WRITE len=2, base 0x100, data 0x11111111, 0x22222222, checksum 0x33333333, gnt/rvalid immediate → writes to 0x100 and 0x104; done_o one pulse; core_rst_no=0.
2. Test 1 then RUN header 0x5A000000 → core_rst_no=1; err_code_o=0; busy_o=0 within 2 cycles.
3. Checksum word 0x33333334 → both writes occur; err_valid_o pulses; err_code_o=2; no done_o.
4. Header 0xA5000000 (len 0), then header 0x77000001 → err_code_o=1 each time; no mem_req_o.
5. WRITE len=4, SS deasserted after 2 data words → two writes, then err_code_o=3; next valid packet completes normally.
6. mem_gnt_i held low 10 cycles; rx_valid_i burst of FIFO_DEPTH+2 words → mem_req_o/addr/data stable throughout; overflow_o=1; base 0xFFFFFFFC len 2 wraps the second write to 0x0.

Source files
------------

// File: rtl/spi_mem_loader.sv
// -----------------------------------------------------------------------------
// spi_mem_loader
//   Boot loader between the SPI slave and the instruction/data RAM port.
//   Received SPI words are buffered in a small FIFO and parsed as framed
//   packets:
//     header (opcode[DATA_WIDTH-1 -:8], len[15:0]) -> base address ->
//     len data words -> checksum (sum of data words mod 2^DATA_WIDTH).
//   Each data word becomes one memory write; only one transaction is ever
//   outstanding. The core is kept in reset until a RUN header arrives.
//
// Ports
//   clk_sys_i, rst_sys_i   system clock, asynchronous active-high reset
//   rx_valid_i, rx_data_i  one-cycle word strobe and word from the SPI slave
//   ss_i                   pad chip select (active low, asynchronous)
//   mem_*                  request/grant/response memory write port
//   core_rst_no            core reset (active low), 0 out of reset
//   busy_o                 FSM not idle
//   done_o                 pulse: packet written and checksum matched
//   err_valid_o/err_code_o pulse + held code (1 header, 2 checksum, 3 abort)
//   overflow_o             sticky: a word arrived while the FIFO was full
// -----------------------------------------------------------------------------
module spi_mem_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                    clk_sys_i,
  input  logic                    rst_sys_i,
  input  logic                    rx_valid_i,
  input  logic [DATA_WIDTH-1:0]   rx_data_i,
  input  logic                    ss_i,
  output logic                    mem_req_o,
  input  logic                    mem_gnt_i,
  input  logic                    mem_rvalid_i,
  output logic                    mem_we_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic                    core_rst_no,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_valid_o,
  output logic [1:0]              err_code_o,
  output logic                    overflow_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int BE_W  = DATA_WIDTH / 8;

  localparam logic [PTR_W:0]          PTR_ONE   = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0]   ADDR_STEP = ADDR_WIDTH'(BE_W);

  localparam logic [7:0] OP_WRITE = 8'hA5;
  localparam logic [7:0] OP_RUN   = 8'h5A;

  localparam logic [1:0] ERR_NONE   = 2'd0;
  localparam logic [1:0] ERR_HEADER = 2'd1;
  localparam logic [1:0] ERR_CSUM   = 2'd2;
  localparam logic [1:0] ERR_ABORT  = 2'd3;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_REQ   = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;
  localparam logic [2:0] S_CHECK = 3'd5;

  // ---------------------------------------------------------------------------
  // Registers and wires
  // ---------------------------------------------------------------------------
  logic                  r_ss_meta;
  logic                  r_ss_hi;

  logic [DATA_WIDTH-1:0] r_fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0]        r_wr_ptr;
  logic [PTR_W:0]        r_rd_ptr;
  logic                  r_overflow;

  logic [2:0]            r_state;
  logic [15:0]           r_remaining;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_sum;
  logic                  r_req;
  logic                  r_core_rst_n;
  logic                  r_done;
  logic                  r_err_valid;
  logic [1:0]            r_err_code;

  logic                  w_empty;
  logic                  w_full;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_flush;
  logic                  w_abort;
  logic [DATA_WIDTH-1:0] w_head;
  logic [7:0]            w_opcode;
  logic [15:0]           w_len;
  logic                  w_is_write;
  logic                  w_is_run;
  logic [ADDR_WIDTH-1:0] w_head_addr;

  // ---------------------------------------------------------------------------
  // FIFO status and header decode
  // ---------------------------------------------------------------------------
  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                      (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  assign w_head     = r_fifo_mem[r_rd_ptr[PTR_W-1:0]];
  assign w_opcode   = w_head[DATA_WIDTH-1:DATA_WIDTH-8];
  assign w_len      = w_head[15:0];
  assign w_is_write = (w_opcode == OP_WRITE) && (w_len != 16'd0);
  assign w_is_run   = (w_opcode == OP_RUN);

  // A full FIFO still accepts a word when the FSM pops in the same cycle.
  assign w_push = rx_valid_i && (!w_full || w_pop);

  // Base address word: truncate or zero-extend to the address width.
  if (ADDR_WIDTH <= DATA_WIDTH) begin : g_addr_trunc
    assign w_head_addr = w_head[ADDR_WIDTH-1:0];
  end else begin : g_addr_ext
    assign w_head_addr = {{(ADDR_WIDTH-DATA_WIDTH){1'b0}}, w_head};
  end

  // Pop/flush/abort decisions for the current state.
  always_comb begin
    w_pop   = 1'b0;
    w_abort = 1'b0;
    w_flush = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_pop   = !w_empty;
        w_flush = !w_empty && !w_is_write && !w_is_run;
      end
      S_ADDR, S_DATA, S_CHECK: begin
        w_pop   = !w_empty;
        w_abort = w_empty && r_ss_hi;
        w_flush = w_empty && r_ss_hi;
      end
      default: begin
        w_pop   = 1'b0;
        w_abort = 1'b0;
        w_flush = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Chip-select synchroniser (reset to the deselected level)
  // ---------------------------------------------------------------------------
  // Two-flop synchroniser for the pad chip select.
  always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
    if (rst_sys_i) begin
      r_ss_meta <= 1'b1;
      r_ss_hi   <= 1'b1;
    end else begin
      r_ss_meta <= ss_i;
      r_ss_hi   <= r_ss_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Receive FIFO
  // ---------------------------------------------------------------------------
  // FIFO storage; contents are qualified by the pointers so no reset needed.
  always_ff @(posedge clk_sys_i) begin
    if (w_push) begin
      r_fifo_mem[r_wr_ptr[PTR_W-1:0]] <= rx_data_i;
    end
  end

  // FIFO pointers and sticky overflow flag.
  always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
    if (rst_sys_i) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      // Flushing drops every stored word but keeps a word arriving this cycle.
      if (w_flush) begin
        r_rd_ptr <= r_wr_ptr;
      end else if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      if (rx_valid_i && !w_push) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Packet FSM and memory request
  // ---------------------------------------------------------------------------
  // Packet parser, write sequencing, checksum and status outputs.
  always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
    if (rst_sys_i) begin
      r_state      <= S_IDLE;
      r_remaining  <= 16'd0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_sum        <= '0;
      r_req        <= 1'b0;
      r_core_rst_n <= 1'b0;
      r_done       <= 1'b0;
      r_err_valid  <= 1'b0;
      r_err_code   <= ERR_NONE;
    end else begin
      r_done      <= 1'b0;
      r_err_valid <= 1'b0;
      if (w_abort) begin
        r_err_code  <= ERR_ABORT;
        r_err_valid <= 1'b1;
        r_state     <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (!w_empty) begin
              if (w_is_write) begin
                r_remaining  <= w_len;
                r_core_rst_n <= 1'b0;
                r_err_code   <= ERR_NONE;
                r_state      <= S_ADDR;
              end else if (w_is_run) begin
                r_core_rst_n <= 1'b1;
                r_err_code   <= ERR_NONE;
              end else begin
                r_err_code  <= ERR_HEADER;
                r_err_valid <= 1'b1;
              end
            end
          end
          S_ADDR: begin
            if (!w_empty) begin
              r_addr  <= w_head_addr;
              r_sum   <= '0;
              r_state <= S_DATA;
            end
          end
          S_DATA: begin
            if (!w_empty) begin
              r_sum   <= r_sum + w_head;
              r_wdata <= w_head;
              r_req   <= 1'b1;
              r_state <= S_REQ;
            end
          end
          S_REQ: begin
            // Address/data stay frozen until the grant; request drops next cycle.
            if (mem_gnt_i) begin
              r_req   <= 1'b0;
              r_state <= S_RESP;
            end
          end
          S_RESP: begin
            if (mem_rvalid_i) begin
              r_addr      <= r_addr + ADDR_STEP;
              r_remaining <= r_remaining - 16'd1;
              if (r_remaining == 16'd1) begin
                r_state <= S_CHECK;
              end else begin
                r_state <= S_DATA;
              end
            end
          end
          S_CHECK: begin
            if (!w_empty) begin
              if (w_head == r_sum) begin
                r_done <= 1'b1;
              end else begin
                r_err_code  <= ERR_CSUM;
                r_err_valid <= 1'b1;
              end
              r_state <= S_IDLE;
            end
          end
          default: begin
            r_req   <= 1'b0;
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (all derived directly from registers)
  // ---------------------------------------------------------------------------
  assign mem_req_o   = r_req;
  assign mem_we_o    = r_req;
  assign mem_be_o    = {BE_W{r_req}};
  assign mem_addr_o  = r_addr;
  assign mem_wdata_o = r_wdata;
  assign core_rst_no = r_core_rst_n;
  assign busy_o      = (r_state != S_IDLE);
  assign done_o      = r_done;
  assign err_valid_o = r_err_valid;
  assign err_code_o  = r_err_code;
  assign overflow_o  = r_overflow;

endmodule

// File: tb/tb_spi_mem_loader.sv
module tb_spi_mem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_valid = 1'b0;
  logic [31:0] rx_data = 32'h0;
  logic        ss = 1'b1;
  logic        gnt = 1'b1;
  logic        rvalid;
  logic        mem_req_o, mem_we_o, core_rst_no, busy_o, done_o, err_valid_o, overflow_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic [1:0]  err_code_o;

  int n_vec = 0;
  int n_mis = 0;

  spi_mem_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .FIFO_DEPTH(8)) dut (
    .clk_sys_i(clk), .rst_sys_i(rst), .rx_valid_i(rx_valid), .rx_data_i(rx_data),
    .ss_i(ss), .mem_req_o(mem_req_o), .mem_gnt_i(gnt), .mem_rvalid_i(rvalid),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_be_o(mem_be_o), .core_rst_no(core_rst_no), .busy_o(busy_o), .done_o(done_o),
    .err_valid_o(err_valid_o), .err_code_o(err_code_o), .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  // Memory model: response one cycle after each granted request.
  always @(posedge clk or posedge rst) begin
    if (rst) rvalid <= 1'b0;
    else     rvalid <= mem_req_o && gnt;
  end

  // Monitor on the falling edge: log granted writes and count pulse cycles.
  logic [31:0] wr_addr [64];
  logic [31:0] wr_data [64];
  int wr_cnt = 0, done_cnt = 0, errv_cnt = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_req_o && gnt) begin
        wr_addr[wr_cnt % 64] <= mem_addr_o;
        wr_data[wr_cnt % 64] <= mem_wdata_o;
        wr_cnt <= wr_cnt + 1;
      end
      if (done_o)      done_cnt <= done_cnt + 1;
      if (err_valid_o) errv_cnt <= errv_cnt + 1;
    end
  end

  typedef struct packed {
    logic [31:0]      hdr;
    logic [31:0]      base;
    logic [1:0]       n;
    logic [2:0][31:0] d;
    logic [31:0]      cks;
    logic [1:0]       exp_wr;
    logic [31:0]      exp_a0;
    logic             exp_done;
    logic             exp_errv;
    logic [1:0]       exp_code;
    logic             exp_rst;
  } vec_t;

  vec_t vecs [8];

  function automatic vec_t mk(input logic [31:0] hdr, input logic [31:0] base,
                              input logic [1:0] n, input logic [31:0] d0,
                              input logic [31:0] d1, input logic [31:0] d2,
                              input logic [31:0] cks, input logic [1:0] exp_wr,
                              input logic [31:0] exp_a0, input logic exp_done,
                              input logic exp_errv, input logic [1:0] exp_code,
                              input logic exp_rst);
    vec_t v;
    v.hdr = hdr; v.base = base; v.n = n;
    v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.cks = cks;
    v.exp_wr = exp_wr; v.exp_a0 = exp_a0; v.exp_done = exp_done;
    v.exp_errv = exp_errv; v.exp_code = exp_code; v.exp_rst = exp_rst;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w);
    rx_valid = 1'b1;
    rx_data  = w;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k;
    repeat (3) tick();
    k = 0;
    while (busy_o && k < 200) begin
      tick();
      k++;
    end
    chk({name, "_idle"}, 64'(busy_o), 64'd0);
    repeat (2) tick();
  endtask

  task automatic wait_req(input string name);
    int k;
    k = 0;
    while (!mem_req_o && k < 50) begin
      tick();
      k++;
    end
    chk({name, "_req_seen"}, 64'(mem_req_o), 64'd1);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int bw, bd, be;
    string nm;
    nm = $sformatf("vec%0d", idx);
    bw = wr_cnt; bd = done_cnt; be = errv_cnt;
    push_word(v.hdr);
    if (v.n != 2'd0) begin
      push_word(v.base);
      for (int i = 0; i < int'(v.n); i++) push_word(v.d[i]);
      push_word(v.cks);
    end
    wait_idle(nm);
    chk({nm, "_writes"}, 64'(wr_cnt - bw), 64'(v.exp_wr));
    for (int i = 0; i < int'(v.exp_wr); i++) begin
      chk($sformatf("%s_addr%0d", nm, i), 64'(wr_addr[(bw + i) % 64]), 64'(v.exp_a0 + 32'(4 * i)));
      chk($sformatf("%s_data%0d", nm, i), 64'(wr_data[(bw + i) % 64]), 64'(v.d[i]));
    end
    chk({nm, "_done"}, 64'(done_cnt - bd), 64'(v.exp_done));
    chk({nm, "_errv"}, 64'(errv_cnt - be), 64'(v.exp_errv));
    chk({nm, "_code"}, 64'(err_code_o), 64'(v.exp_code));
    chk({nm, "_core_rst_n"}, 64'(core_rst_no), 64'(v.exp_rst));
  endtask

  initial begin
    int bw, bd, be, k;
    //          hdr           base          n     d0            d1            d2     cks           wr    a0            dn    ev    code  rst
    vecs[0] = mk(32'hA5000002, 32'h00000100, 2'd2, 32'h11111111, 32'h22222222, 32'h0, 32'h33333333, 2'd2, 32'h00000100, 1'b1, 1'b0, 2'd0, 1'b0);
    vecs[1] = mk(32'h5A000000, 32'h0,        2'd0, 32'h0,        32'h0,        32'h0, 32'h0,        2'd0, 32'h0,        1'b0, 1'b0, 2'd0, 1'b1);
    vecs[2] = mk(32'hA5000002, 32'h00000200, 2'd2, 32'h11111111, 32'h22222222, 32'h0, 32'h33333334, 2'd2, 32'h00000200, 1'b0, 1'b1, 2'd2, 1'b0);
    vecs[3] = mk(32'hA5000000, 32'h0,        2'd0, 32'h0,        32'h0,        32'h0, 32'h0,        2'd0, 32'h0,        1'b0, 1'b1, 2'd1, 1'b0);
    vecs[4] = mk(32'h77000001, 32'h0,        2'd0, 32'h0,        32'h0,        32'h0, 32'h0,        2'd0, 32'h0,        1'b0, 1'b1, 2'd1, 1'b0);
    vecs[5] = mk(32'h5A000000, 32'h0,        2'd0, 32'h0,        32'h0,        32'h0, 32'h0,        2'd0, 32'h0,        1'b0, 1'b0, 2'd0, 1'b1);
    vecs[6] = mk(32'h00000003, 32'h0,        2'd0, 32'h0,        32'h0,        32'h0, 32'h0,        2'd0, 32'h0,        1'b0, 1'b1, 2'd1, 1'b1);
    vecs[7] = mk(32'hA5000003, 32'h00000040, 2'd3, 32'h00000001, 32'h00000002, 32'h3, 32'h00000006, 2'd3, 32'h00000040, 1'b1, 1'b0, 2'd0, 1'b0);

    // Reset state
    repeat (3) tick();
    chk("rst_req",      64'(mem_req_o),   64'd0);
    chk("rst_we",       64'(mem_we_o),    64'd0);
    chk("rst_be",       64'(mem_be_o),    64'd0);
    chk("rst_addr",     64'(mem_addr_o),  64'd0);
    chk("rst_wdata",    64'(mem_wdata_o), 64'd0);
    chk("rst_core",     64'(core_rst_no), 64'd0);
    chk("rst_busy",     64'(busy_o),      64'd0);
    chk("rst_done",     64'(done_o),      64'd0);
    chk("rst_errv",     64'(err_valid_o), 64'd0);
    chk("rst_code",     64'(err_code_o),  64'd0);
    chk("rst_overflow", 64'(overflow_o),  64'd0);
    rst = 1'b0;
    ss  = 1'b0;
    repeat (3) tick();

    // Table-driven packets and single-word commands
    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Abort: WRITE len 4, chip select released after two data words
    bw = wr_cnt; be = errv_cnt;
    push_word(32'hA5000004);
    push_word(32'h00000300);
    push_word(32'h0000000A);
    push_word(32'h0000000B);
    k = 0;
    while (wr_cnt - bw < 2 && k < 100) begin tick(); k++; end
    ss = 1'b1;
    k = 0;
    while (errv_cnt == be && k < 50) begin tick(); k++; end
    chk("abort_errv",   64'(errv_cnt - be), 64'd1);
    chk("abort_code",   64'(err_code_o),    64'd3);
    chk("abort_writes", 64'(wr_cnt - bw),   64'd2);
    chk("abort_addr0",  64'(wr_addr[bw % 64]),       64'h300);
    chk("abort_addr1",  64'(wr_addr[(bw + 1) % 64]), 64'h304);
    repeat (2) tick();
    chk("abort_busy",   64'(busy_o), 64'd0);
    ss = 1'b0;
    repeat (3) tick();
    run_vec(8, vecs[0]);

    // Stalled grant, overflow burst, address wrap
    gnt = 1'b0;
    bw = wr_cnt; bd = done_cnt; be = errv_cnt;
    push_word(32'hA5000002);
    push_word(32'hFFFFFFFC);
    push_word(32'hAAAA0000);
    wait_req("stall");
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("stall_req%0d", i),   64'(mem_req_o),   64'd1);
      chk($sformatf("stall_addr%0d", i),  64'(mem_addr_o),  64'hFFFFFFFC);
      chk($sformatf("stall_wdata%0d", i), 64'(mem_wdata_o), 64'hAAAA0000);
      if (i == 0)      push_word(32'h5555FFFF);
      else if (i == 1) push_word(32'hFFFFFFFF);
      else             push_word(32'h00000000);
    end
    chk("stall_be",       64'(mem_be_o),   64'hF);
    chk("stall_overflow", 64'(overflow_o), 64'd1);
    gnt = 1'b1;
    wait_idle("stall");
    chk("wrap_writes", 64'(wr_cnt - bw), 64'd2);
    chk("wrap_addr0",  64'(wr_addr[bw % 64]),       64'hFFFFFFFC);
    chk("wrap_addr1",  64'(wr_addr[(bw + 1) % 64]), 64'h0);
    chk("wrap_data1",  64'(wr_data[(bw + 1) % 64]), 64'h5555FFFF);
    chk("wrap_done",   64'(done_cnt - bd), 64'd1);
    chk("wrap_errv",   64'(errv_cnt - be), 64'd1);
    chk("wrap_code",   64'(err_code_o),    64'd1);
    chk("wrap_overflow_sticky", 64'(overflow_o), 64'd1);

    // Asynchronous reset while a request is pending
    gnt = 1'b0;
    push_word(32'hA5000001);
    push_word(32'h00000500);
    push_word(32'h00001234);
    wait_req("arst");
    #2 rst = 1'b1;
    #1;
    chk("arst_req",      64'(mem_req_o),   64'd0);
    chk("arst_busy",     64'(busy_o),      64'd0);
    chk("arst_overflow", 64'(overflow_o),  64'd0);
    chk("arst_code",     64'(err_code_o),  64'd0);
    chk("arst_addr",     64'(mem_addr_o),  64'd0);
    gnt = 1'b1;
    tick();
    rst = 1'b0;
    bw = wr_cnt;
    repeat (10) tick();
    chk("arst_quiet_busy",   64'(busy_o),       64'd0);
    chk("arst_quiet_writes", 64'(wr_cnt - bw),  64'd0);
    run_vec(9, vecs[7]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
